// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator with per-channel volume and a saturating mixer.
// Define TONE_SYNTH_RAMP_EN to make envelopes ramp one level per RAMP_DIV cycles.
module tone_synth #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned AUD_W    = 16,
    parameter int unsigned VOL_W    = 4,
    parameter int unsigned AMP_STEP = 64,
    parameter int unsigned RAMP_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*DIV_W-1:0]    note_div,
    input  logic [NCH*VOL_W-1:0]    volume,
    output logic [NCH*AUD_W-1:0]    audio_ch,
    output logic signed [AUD_W-1:0] audio_mix,
    output logic [NCH-1:0]          active
);

    // Enough headroom for up to eight full-scale channels before clamping.
    localparam int unsigned MixW = AUD_W + 4;
    localparam logic signed [MixW-1:0] MixMax = {{(MixW-AUD_W+1){1'b0}}, {(AUD_W-1){1'b1}}};
    localparam logic signed [MixW-1:0] MixMin = {{(MixW-AUD_W+1){1'b1}}, {(AUD_W-1){1'b0}}};

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("tone_synth: NCH must be 1..8");
    end
    if ((2 ** VOL_W - 1) * AMP_STEP > 2 ** (AUD_W - 1) - 1) begin : g_bad_amp
        $error("tone_synth: full-scale amplitude overflows AUD_W");
    end
    if (RAMP_DIV < 1) begin : g_bad_ramp
        $error("tone_synth: RAMP_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_c  [NCH];
    logic [VOL_W-1:0] target [NCH];
    logic [NCH-1:0]   muted;

    logic [DIV_W-1:0] cnt_q [NCH];
    logic [DIV_W-1:0] cnt_d [NCH];
    logic [VOL_W-1:0] env_q [NCH];
    logic [VOL_W-1:0] env_d [NCH];
    logic [NCH-1:0]   phase_q, phase_d;

    logic [AUD_W-1:0]        amp [NCH];
    logic signed [AUD_W-1:0] smp [NCH];
    logic signed [MixW-1:0]  sum;

    logic [NCH*AUD_W-1:0]    audio_ch_q, audio_ch_d;
    logic signed [AUD_W-1:0] mix_q, mix_d;
    logic [NCH-1:0]          active_q, active_d;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign div_c[c]  = note_div[c*DIV_W +: DIV_W];
        assign muted[c]  = (div_c[c] <= DIV_W'(1));
        assign target[c] = muted[c] ? '0 : volume[c*VOL_W +: VOL_W];
    end

    // Comparing with >= lets a lowered divider wrap immediately instead of counting up.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c]   = cnt_q[c];
            phase_d[c] = phase_q[c];
            if (muted[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] >= div_c[c]) begin
                cnt_d[c]   = '0;
                phase_d[c] = ~phase_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
            end
        end
    end

`ifdef TONE_SYNTH_RAMP_EN
    localparam int unsigned TickW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [TickW-1:0] tick_q, tick_d;
    logic             ramp_step;

    assign ramp_step = (tick_q == TickW'(RAMP_DIV - 1));
    assign tick_d    = ramp_step ? '0 : tick_q + TickW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            env_d[c] = env_q[c];
            if (ramp_step) begin
                if (env_q[c] < target[c]) begin
                    env_d[c] = env_q[c] + VOL_W'(1);
                end else if (env_q[c] > target[c]) begin
                    env_d[c] = env_q[c] - VOL_W'(1);
                end
            end
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            env_d[c] = target[c];
        end
    end
`endif

    // Outputs are built from the current (pre-update) phase/env so all three stay aligned.
    always_comb begin
        sum        = '0;
        audio_ch_d = '0;
        active_d   = '0;
        for (int c = 0; c < NCH; c++) begin
            amp[c] = AUD_W'(32'(env_q[c]) * AMP_STEP);
            smp[c] = phase_q[c] ? -amp[c] : amp[c];
            sum    = sum + MixW'(smp[c]);
            audio_ch_d[c*AUD_W +: AUD_W] = smp[c];
            active_d[c] = (env_q[c] != '0);
        end
        if (sum > MixMax) begin
            mix_d = MixMax[AUD_W-1:0];
        end else if (sum < MixMin) begin
            mix_d = MixMin[AUD_W-1:0];
        end else begin
            mix_d = sum[AUD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
                env_q[c] <= '0;
            end
            phase_q    <= '0;
            audio_ch_q <= '0;
            mix_q      <= '0;
            active_q   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
                env_q[c] <= env_d[c];
            end
            phase_q    <= phase_d;
            audio_ch_q <= audio_ch_d;
            mix_q      <= mix_d;
            active_q   <= active_d;
        end
    end

    assign audio_ch  = audio_ch_q;
    assign audio_mix = mix_q;
    assign active    = active_q;

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent tone channels, 1..8.
REQ-002 SHALL have parameter DIV_W, default 22: width of each channel's half-period divider.
REQ-003 SHALL have parameter AUD_W, default 16: signed sample width.
REQ-004 SHALL have parameter VOL_W, default 4: volume/envelope width; levels 0..2^VOL_W-1.
REQ-005 SHALL have parameter AMP_STEP, default 64: amplitude per envelope level; (2^VOL_W-1)*AMP_STEP SHALL NOT exceed 2^(AUD_W-1)-1.
REQ-006 SHALL have parameter RAMP_DIV, default 1000: clk cycles per envelope step, >=1.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 note_div  input  NCH*DIV_W  channel c divider at [c*DIV_W +: DIV_W]; value <=1 means mute.
REQ-010 volume  input  NCH*VOL_W  channel c target level at [c*VOL_W +: VOL_W].
REQ-011 audio_ch  output  NCH*AUD_W  registered signed per-channel sample, channel c at [c*AUD_W +: AUD_W].
REQ-012 audio_mix  output  AUD_W  registered saturated signed sum of all channels.
REQ-013 active  output  NCH  bit c high while channel c envelope is nonzero.

Function
REQ-014 Each channel SHALL hold a DIV_W-bit counter cnt and a phase bit.
REQ-015 When note_div_c > 1: cnt >= note_div_c -> cnt <= 0 and phase toggles; otherwise cnt <= cnt+1 (a divider lowered below cnt SHALL wrap to 0 next cycle, never count through 2^DIV_W).
REQ-016 Square-wave period SHALL be 2*(note_div_c+1) clk cycles.
REQ-017 When note_div_c <= 1: cnt held at 0, phase frozen, envelope target forced to 0.
REQ-018 Envelope target SHALL be volume_c unless muted per REQ-017.
REQ-019 amp_c = env_c*AMP_STEP; audio_ch_c SHALL be +amp_c when phase=0, -amp_c (two's complement) when phase=1.
REQ-020 audio_ch and audio_mix SHALL be registered from the same cycle's phase/env state (1-cycle latency, mutually aligned).
REQ-021 audio_mix SHALL be the full-precision signed sum of all audio_ch values, clamped to [-2^(AUD_W-1), 2^(AUD_W-1)-1].
REQ-022 active_c SHALL be registered as (env_c != 0), aligned with audio_ch.
REQ-023 Channels SHALL be fully independent; simultaneous toggles on any number of channels SHALL all take effect in the same cycle.

Reset
REQ-024 While rst is high at a clk edge: all cnt, phase, env, ramp tick counter, audio_ch, audio_mix, active SHALL become 0.
REQ-025 Reset asserted mid-ramp or mid-period SHALL abort it; after deassertion envelopes restart from 0 and counters from 0.

Configuration
REQ-026 Macro TONE_SYNTH_RAMP_EN SHALL select envelope ramping.
REQ-027 With TONE_SYNTH_RAMP_EN defined: a shared tick counter counts 0..RAMP_DIV-1; on the cycle it equals RAMP_DIV-1 it returns to 0 and every env moves one level toward its target; env equal to target holds.
REQ-028 With TONE_SYNTH_RAMP_EN undefined: env_c <= target every cycle; tick counter and RAMP_DIV unused.

Verification
REQ-029 Ramp off, defaults: rst, then note_div0=3, volume0=15 -> audio_ch0 alternates +960 / -960 every 4 cycles (period 8); active0=1.
REQ-030 Ramp on, RAMP_DIV=4: volume0 0->15 -> amplitude rises 64 per 4 cycles, reaches 960 after 60 cycles; then note_div0=1 -> amplitude falls 64 per 4 cycles to 0, phase frozen, active0 drops with the 0 sample.
REQ-031 note_div0=100 with cnt=50, change to 10 -> next cycle cnt=0 and phase toggled; subsequent half-periods 11 cycles.
REQ-032 NCH=4, AMP_STEP=2048, ramp off, all volume=15, equal divider, reset aligned -> each audio_ch = ±30720, audio_mix = 32767 in phase 0 and -32768 in phase 1.
REQ-033 Ramp on, env0 at 8: rst pulsed 1 cycle -> next cycle all outputs 0; after release env0 restarts at 0 and ramps one level per RAMP_DIV cycles.
